fetch_command_issuer: RTL and testbench

- Sits directly upstream of the layer-engine egress interface and drives its 128-bit command input.
- Accepts one fetch job: base address plus byte length.
- Splits the job into read-command packets. Each chunk is bounded by C_MAX_CHUNK_BYTES and never crosses a 4 KB boundary.
- Issues one chunk at a time and waits until the chunk's data beats have been returned on the egress output before issuing the next.

---
 rtl/fetch_command_issuer_pkg.sv | 28 ++
 rtl/fetch_command_issuer_chunk_calc.sv | 27 ++
 rtl/fetch_command_issuer.sv | 176 +++++++++++++++++
 tb/tb_fetch_command_issuer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_command_issuer_pkg.sv
// Shared definitions for the fetch command issuer: FSM encodings, command field
// offsets and page/beat geometry.
package fetch_command_issuer_pkg;

   typedef enum logic [4:0] {
      S_IDLE      = 5'b00001,
      S_CALC      = 5'b00010,
      S_ISSUE     = 5'b00100,
      S_WAIT_DATA = 5'b01000,
      S_DONE      = 5'b10000
   } state_e;

   localparam int CMD_ADDR_MSB = 127;
   localparam int CMD_ADDR_LSB = 64;
   localparam int CMD_LEN_MSB  = 63;
   localparam int CMD_LEN_LSB  = 28;

   localparam int LEN_W        = 36;
   localparam int PAGE_BYTES   = 4096;
   localparam int PACKET_WIDTH = 128;
   localparam int BEAT_BYTES   = PACKET_WIDTH / 8;

   function automatic logic [LEN_W-1:0] min_len(input logic [LEN_W-1:0] a,
                                                input logic [LEN_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/fetch_command_issuer_chunk_calc.sv
// Combinational chunk sizer: clamps to remaining bytes, max chunk and the 4 KB
// page boundary, then counts data beats including the start offset in the beat.
module fetch_chunk_calc
   import fetch_command_issuer_pkg::*;
#(
   parameter int C_MAX_CHUNK_BYTES = 1024,
   parameter int C_BEAT_BYTES      = BEAT_BYTES
) (
   input  logic [11:0]      page_offset,
   input  logic [LEN_W-1:0] remaining,
   output logic [LEN_W-1:0] chunk,
   output logic [LEN_W-1:0] beats
);

   localparam int BEAT_SHIFT = $clog2(C_BEAT_BYTES);

   logic [LEN_W-1:0] page_left;
   logic [LEN_W-1:0] beat_offset;

   always_comb begin
      page_left   = LEN_W'(PAGE_BYTES) - {24'd0, page_offset};
      chunk       = min_len(min_len(remaining, LEN_W'(C_MAX_CHUNK_BYTES)), page_left);
      beat_offset = {24'd0, page_offset} & LEN_W'(C_BEAT_BYTES - 1);
      beats       = (beat_offset + chunk + LEN_W'(C_BEAT_BYTES - 1)) >> BEAT_SHIFT;
   end

endmodule

// File: rtl/fetch_command_issuer.sv
// Splits a fetch job into page-safe read commands, issuing one at a time and
// waiting for its data beats. FETCH_ISSUER_TIMEOUT_EN adds a WAIT_DATA watchdog.
module fetch_command_issuer
   import fetch_command_issuer_pkg::*;
#(
   parameter int C_PACKET_WIDTH    = PACKET_WIDTH,
   parameter int C_MAX_CHUNK_BYTES = 1024,
   parameter int C_TIMEOUT_CYCLES  = 65535
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      job_valid,
   output logic                      job_ready,
   input  logic [63:0]               job_address,
   input  logic [LEN_W-1:0]          job_length,
   output logic                      job_done,
   output logic                      cmd_valid,
   input  logic                      cmd_accept,
   output logic [C_PACKET_WIDTH-1:0] cmd_payload,
   input  logic                      beat_valid,
   input  logic                      beat_accept,
   output logic                      busy,
   output logic [15:0]               chunk_count
`ifdef FETCH_ISSUER_TIMEOUT_EN
   ,output logic                     timeout_err
`endif
);

   state_e           state_q, state_d;
   logic [63:0]      cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic [LEN_W-1:0] chunk_q, chunk_d;
   logic [LEN_W-1:0] beats_exp_q, beats_exp_d;
   logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [15:0]      chunk_count_q, chunk_count_d;
   logic [LEN_W-1:0] calc_chunk, calc_beats;
   logic             job_hs, cmd_hs, beat_hs, wait_done, wd_expire;

   fetch_chunk_calc #(
      .C_MAX_CHUNK_BYTES (C_MAX_CHUNK_BYTES),
      .C_BEAT_BYTES      (C_PACKET_WIDTH / 8)
   ) u_chunk_calc (
      .page_offset (cur_addr_q[11:0]),
      .remaining   (remaining_q),
      .chunk       (calc_chunk),
      .beats       (calc_beats)
   );

   assign job_hs    = job_valid && job_ready;
   assign cmd_hs    = cmd_valid && cmd_accept;
   assign beat_hs   = (state_q == S_WAIT_DATA) && beat_valid && beat_accept;
   assign wait_done = beat_hs && ((beat_cnt_q + LEN_W'(1)) >= beats_exp_q);

`ifdef FETCH_ISSUER_TIMEOUT_EN
   logic [31:0] wd_q, wd_d;
   logic        timeout_q, timeout_d;

   // Watchdog counts beat-less WAIT_DATA cycles; restarts on every beat.
   assign wd_expire = (state_q == S_WAIT_DATA) && !beat_hs &&
                      ((wd_q + 32'd1) >= 32'(C_TIMEOUT_CYCLES));

   always_comb begin
      wd_d      = wd_q;
      timeout_d = timeout_q;
      if (cmd_hs) begin
         wd_d = 32'd0;
      end else if (state_q == S_WAIT_DATA) begin
         wd_d = beat_hs ? 32'd0 : wd_q + 32'd1;
      end
      if (job_hs) begin
         timeout_d = 1'b0;
      end else if (wd_expire) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q      <= 32'd0;
         timeout_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_err = timeout_q;
`else
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (job_hs) state_d = S_CALC;
         S_CALC:      state_d = (remaining_q == '0) ? S_DONE : S_ISSUE;
         S_ISSUE:     if (cmd_hs) state_d = S_WAIT_DATA;
         S_WAIT_DATA: begin
            if (wait_done) begin
               state_d = S_CALC;
            end else if (wd_expire) begin
               state_d = S_DONE;
            end
         end
         S_DONE:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cur_addr_d    = cur_addr_q;
      remaining_d   = remaining_q;
      chunk_d       = chunk_q;
      beats_exp_d   = beats_exp_q;
      beat_cnt_d    = beat_cnt_q;
      chunk_count_d = chunk_count_q;
      if (job_hs) begin
         cur_addr_d    = job_address;
         remaining_d   = job_length;
         chunk_count_d = 16'd0;
      end
      if (state_q == S_CALC) begin
         chunk_d     = calc_chunk;
         beats_exp_d = calc_beats;
      end
      // Address advance wraps modulo 2^64; chunk count sticks at its maximum.
      if (cmd_hs) begin
         cur_addr_d    = cur_addr_q + {28'd0, chunk_q};
         remaining_d   = remaining_q - chunk_q;
         beat_cnt_d    = '0;
         chunk_count_d = (chunk_count_q == 16'hFFFF) ? chunk_count_q : chunk_count_q + 16'd1;
      end
      if (beat_hs) begin
         beat_cnt_d = beat_cnt_q + LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_q    <= '0;
         chunk_count_q <= 16'd0;
      end else begin
         beat_cnt_q    <= beat_cnt_d;
         chunk_count_q <= chunk_count_d;
      end
   end

   always_ff @(posedge clk) begin
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      chunk_q     <= chunk_d;
      beats_exp_q <= beats_exp_d;
   end

   always_comb begin
      job_ready   = (state_q == S_IDLE) && !rst;
      cmd_valid   = (state_q == S_ISSUE);
      job_done    = (state_q == S_DONE);
      busy        = (state_q != S_IDLE);
      chunk_count = chunk_count_q;
      cmd_payload = '0;
      if (state_q == S_ISSUE) begin
         cmd_payload[CMD_ADDR_MSB:CMD_ADDR_LSB] = cur_addr_q;
         cmd_payload[CMD_LEN_MSB:CMD_LEN_LSB]   = chunk_q;
      end
   end

endmodule

// File: tb/tb_fetch_command_issuer.sv
// Directed bench for fetch_command_issuer: table of jobs with hand-computed
// command sequences, plus zero-length, stall, reset and (optional) timeout cases.
module tb_fetch_command_issuer;

   localparam int TO = 100;

   logic          clk = 1'b0;
   logic          rst;
   logic          job_valid;
   logic          job_ready;
   logic [63:0]   job_address;
   logic [35:0]   job_length;
   logic          job_done;
   logic          cmd_valid;
   logic          cmd_accept;
   logic [127:0]  cmd_payload;
   logic          beat_valid;
   logic          beat_accept;
   logic          busy;
   logic [15:0]   chunk_count;
`ifdef FETCH_ISSUER_TIMEOUT_EN
   logic          timeout_err;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_command_issuer #(
      .C_PACKET_WIDTH    (128),
      .C_MAX_CHUNK_BYTES (1024),
      .C_TIMEOUT_CYCLES  (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .job_valid   (job_valid),
      .job_ready   (job_ready),
      .job_address (job_address),
      .job_length  (job_length),
      .job_done    (job_done),
      .cmd_valid   (cmd_valid),
      .cmd_accept  (cmd_accept),
      .cmd_payload (cmd_payload),
      .beat_valid  (beat_valid),
      .beat_accept (beat_accept),
      .busy        (busy),
      .chunk_count (chunk_count)
`ifdef FETCH_ISSUER_TIMEOUT_EN
      ,.timeout_err (timeout_err)
`endif
   );

   typedef struct {
      logic [63:0]       addr;
      logic [35:0]       len;
      int                n;
      logic [2:0][63:0]  caddr;
      logic [2:0][35:0]  clen;
      int                beats [3];
   } vec_t;

   vec_t vecs [6];
   vec_t after_rst;

   function automatic vec_t mk(input logic [63:0] addr, input logic [35:0] len, input int n,
                               input logic [63:0] a0, input logic [35:0] l0, input int b0,
                               input logic [63:0] a1, input logic [35:0] l1, input int b1,
                               input logic [63:0] a2, input logic [35:0] l2, input int b2);
      vec_t v;
      v.addr = addr; v.len = len; v.n = n;
      v.caddr[0] = a0; v.clen[0] = l0; v.beats[0] = b0;
      v.caddr[1] = a1; v.clen[1] = l1; v.beats[1] = b1;
      v.caddr[2] = a2; v.clen[2] = l2; v.beats[2] = b2;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      int w;
      job_valid   = 1'b1;
      job_address = v.addr;
      job_length  = v.len;
      chk("job_ready", 64'(job_ready), 64'd1);
      tick;
      job_valid = 1'b0;
      chk("chunk_count_clr", 64'(chunk_count), 64'd0);
      for (int c = 0; c < v.n; c++) begin
         w = 0;
         while (!cmd_valid && w < 20) begin
            tick;
            w++;
         end
         chk("cmd_latency", 64'(w), 64'd1);
         chk("cmd_addr", cmd_payload[127:64], v.caddr[c]);
         chk("cmd_len", 64'(cmd_payload[63:28]), 64'(v.clen[c]));
         chk("cmd_low", 64'(cmd_payload[27:0]), 64'd0);
         cmd_accept = 1'b1;
         tick;
         cmd_accept = 1'b0;
         chk("cmd_drop", 64'(cmd_valid), 64'd0);
         chk("chunk_count", 64'(chunk_count), 64'(c + 1));
         for (int b = 0; b < v.beats[c]; b++) begin
            if (b == 1) begin
               beat_valid  = 1'b1;
               beat_accept = 1'b0;
               tick;
            end
            beat_valid  = 1'b1;
            beat_accept = 1'b1;
            tick;
         end
         beat_valid  = 1'b0;
         beat_accept = 1'b0;
      end
      chk("done_early", 64'(job_done), 64'd0);
      tick;
      chk("job_done", 64'(job_done), 64'd1);
      tick;
      chk("done_pulse", 64'(job_done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("final_count", 64'(chunk_count), 64'(v.n));
   endtask

   initial begin
      logic [127:0] p0;
      logic         stable;
      int           w;

      vecs[0] = mk(64'h1000, 36'd64, 1, 64'h1000, 36'd64, 4, 64'h0, 36'd0, 0, 64'h0, 36'd0, 0);
      vecs[1] = mk(64'h0F80, 36'h200, 2, 64'h0F80, 36'h80, 8, 64'h1000, 36'h180, 24,
                   64'h0, 36'd0, 0);
      vecs[2] = mk(64'h0, 36'd3000, 3, 64'h0, 36'd1024, 64, 64'h400, 36'd1024, 64,
                   64'h800, 36'd952, 60);
      vecs[3] = mk(64'h3008, 36'd40, 1, 64'h3008, 36'd40, 3, 64'h0, 36'd0, 0, 64'h0, 36'd0, 0);
      vecs[4] = mk(64'h0FFC, 36'd8, 2, 64'h0FFC, 36'd4, 1, 64'h1000, 36'd4, 1,
                   64'h0, 36'd0, 0);
      vecs[5] = mk(64'hFFFF_FFFF_FFFF_FFF0, 36'd32, 2, 64'hFFFF_FFFF_FFFF_FFF0, 36'd16, 1,
                   64'h0, 36'd16, 1, 64'h0, 36'd0, 0);
      after_rst = mk(64'h2000, 36'd16, 1, 64'h2000, 36'd16, 1, 64'h0, 36'd0, 0,
                     64'h0, 36'd0, 0);

      rst = 1'b1; job_valid = 1'b0; job_address = '0; job_length = '0;
      cmd_accept = 1'b0; beat_valid = 1'b0; beat_accept = 1'b0;
      tick;
      tick;
      chk("rst_job_ready", 64'(job_ready), 64'd0);
      chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      chk("rst_payload", 64'(|cmd_payload), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_chunk_count", 64'(chunk_count), 64'd0);
      chk("rst_job_done", 64'(job_done), 64'd0);
      rst = 1'b0;
      tick;
      chk("idle_job_ready", 64'(job_ready), 64'd1);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Zero-length job: no command, done two cycles after accept.
      job_valid = 1'b1; job_address = 64'h7000; job_length = 36'd0;
      tick;
      job_valid = 1'b0;
      chk("len0_cmd_calc", 64'(cmd_valid), 64'd0);
      chk("len0_done_early", 64'(job_done), 64'd0);
      tick;
      chk("len0_done", 64'(job_done), 64'd1);
      chk("len0_cmd_done", 64'(cmd_valid), 64'd0);
      tick;
      chk("len0_pulse", 64'(job_done), 64'd0);
      chk("len0_count", 64'(chunk_count), 64'd0);

      // Stalled command with beats arriving during ISSUE.
      job_valid = 1'b1; job_address = 64'h4000; job_length = 36'd32;
      tick;
      job_valid = 1'b0;
      tick;
      chk("stall_cmd_valid", 64'(cmd_valid), 64'd1);
      p0 = cmd_payload;
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         beat_valid = 1'b1; beat_accept = 1'b1;
         tick;
         if (cmd_payload !== p0 || cmd_valid !== 1'b1) stable = 1'b0;
      end
      chk("stall_stable", 64'(stable), 64'd1);
      chk("stall_addr", p0[127:64], 64'h4000);
      beat_valid = 1'b0; beat_accept = 1'b0;
      cmd_accept = 1'b1;
      tick;
      cmd_accept = 1'b0;
      beat_valid = 1'b1; beat_accept = 1'b1;
      tick;
      beat_valid = 1'b0; beat_accept = 1'b0;
      tick;
      tick;
      chk("stall_busy", 64'(busy), 64'd1);
      chk("stall_not_done", 64'(job_done), 64'd0);
      chk("stall_no_reissue", 64'(cmd_valid), 64'd0);
      beat_valid = 1'b1; beat_accept = 1'b1;
      tick;
      beat_valid = 1'b0; beat_accept = 1'b0;
      tick;
      chk("stall_done", 64'(job_done), 64'd1);
      tick;

      // Reset after 5 of 8 beats, then a fresh job.
      job_valid = 1'b1; job_address = 64'h5000; job_length = 36'd128;
      tick;
      job_valid = 1'b0;
      tick;
      cmd_accept = 1'b1;
      tick;
      cmd_accept = 1'b0;
      beat_valid = 1'b1; beat_accept = 1'b1;
      repeat (5) tick;
      rst = 1'b1;
      chk("mid_rst_job_ready", 64'(job_ready), 64'd0);
      tick;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_cmd_valid", 64'(cmd_valid), 64'd0);
      chk("mid_rst_payload", 64'(|cmd_payload), 64'd0);
      chk("mid_rst_count", 64'(chunk_count), 64'd0);
      chk("mid_rst_done", 64'(job_done), 64'd0);
      rst = 1'b0;
      repeat (3) tick;
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_done", 64'(job_done), 64'd0);
      beat_valid = 1'b0; beat_accept = 1'b0;
      run_vec(after_rst);

`ifdef FETCH_ISSUER_TIMEOUT_EN
      job_valid = 1'b1; job_address = 64'h6000; job_length = 36'd16;
      tick;
      job_valid = 1'b0;
      tick;
      cmd_accept = 1'b1;
      tick;
      cmd_accept = 1'b0;
      w = 0;
      while (!job_done && w < 300) begin
         tick;
         w++;
      end
      chk("timeout_cycles", 64'(w), 64'(TO));
      chk("timeout_err", 64'(timeout_err), 64'd1);
      tick;
      chk("timeout_pulse", 64'(job_done), 64'd0);
      chk("timeout_sticky", 64'(timeout_err), 64'd1);
`else
      w = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
